// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing the single-port unified memory between the CPU and the program loader.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise the loader wins simultaneous requests.
module mem_port_arbiter #(
    parameter int BIT_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [BIT_WIDTH-1:0]  cpu_wdata,
    output logic [BIT_WIDTH-1:0]  cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [BIT_WIDTH-1:0]  ld_wdata,
    output logic [BIT_WIDTH-1:0]  ld_rdata,
    output logic                  ld_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BIT_WIDTH-1:0]  mem_wdata,
    output logic                  mem_we,
    input  logic [BIT_WIDTH-1:0]  mem_rdata,
    output logic [1:0]            dbg_state
);
    // Handshake: a requester holds req/we/addr/wdata stable until it samples ack=1 and
    // drops req on that edge; req still high in the following IDLE cycle is a new transaction.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic       GNT_CPU  = 1'b0;
    localparam logic       GNT_LD   = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t                state;
    logic                  grant;
    logic [3:0]            cnt;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [BIT_WIDTH-1:0]  lat_wdata;
    logic                  pick_ld;

`ifdef MEM_ARB_RR_EN
    logic last_grant;

    // On a tie the requester not served last time wins.
    always_comb begin
        pick_ld = ld_req & (~cpu_req | (last_grant == GNT_CPU));
    end
`else
    always_comb begin
        pick_ld = ld_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= GNT_LD;
            cnt        <= 4'd0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cpu_ack    <= 1'b0;
            ld_ack     <= 1'b0;
            cpu_rdata  <= '0;
            ld_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant <= GNT_LD;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || ld_req) begin
                        grant     <= pick_ld;
                        lat_we    <= pick_ld ? ld_we    : cpu_we;
                        lat_addr  <= pick_ld ? ld_addr  : cpu_addr;
                        lat_wdata <= pick_ld ? ld_wdata : cpu_wdata;
                        cnt       <= CNT_INIT;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= ACK;
                        if (grant == GNT_CPU) begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= mem_rdata;
                        end else begin
                            ld_ack    <= 1'b1;
                            ld_rdata  <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    cpu_ack    <= 1'b0;
                    ld_ack     <= 1'b0;
`ifdef MEM_ARB_RR_EN
                    last_grant <= grant;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst so a reset landing on the final BUSY cycle never commits the write.
    assign mem_we    = rst & (state == BUSY) & (cnt == 4'd0) & lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main instance with WAIT_CYCLES=2 plus a WAIT_CYCLES=1 instance.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        ld_req, ld_we, ld_ack;
    logic [7:0]  ld_addr;
    logic [31:0] ld_wdata, ld_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_we;
    logic [1:0]  dbg_state;

    logic        w1_cpu_req, w1_cpu_we, w1_cpu_ack, w1_cpu_stall;
    logic [7:0]  w1_cpu_addr;
    logic [31:0] w1_cpu_wdata, w1_cpu_rdata;
    logic        w1_ld_req, w1_ld_we, w1_ld_ack;
    logic [7:0]  w1_ld_addr;
    logic [31:0] w1_ld_wdata, w1_ld_rdata;
    logic [7:0]  w1_mem_addr;
    logic [31:0] w1_mem_wdata, w1_mem_rdata;
    logic        w1_mem_we;
    logic [1:0]  w1_dbg_state;

    logic [31:0] mem [256];
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    int          we_cnt = 0;
    int          cpu_ack_cnt = 0;
    int          ld_ack_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.BIT_WIDTH(32), .ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    mem_port_arbiter #(.BIT_WIDTH(32), .ADDR_WIDTH(8), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .cpu_req(w1_cpu_req), .cpu_we(w1_cpu_we), .cpu_addr(w1_cpu_addr), .cpu_wdata(w1_cpu_wdata),
        .cpu_rdata(w1_cpu_rdata), .cpu_ack(w1_cpu_ack), .cpu_stall(w1_cpu_stall),
        .ld_req(w1_ld_req), .ld_we(w1_ld_we), .ld_addr(w1_ld_addr), .ld_wdata(w1_ld_wdata),
        .ld_rdata(w1_ld_rdata), .ld_ack(w1_ld_ack),
        .mem_addr(w1_mem_addr), .mem_wdata(w1_mem_wdata), .mem_we(w1_mem_we), .mem_rdata(w1_mem_rdata),
        .dbg_state(w1_dbg_state)
    );

    // Memory model: combinational read, write on the clock edge while mem_we is high.
    assign mem_rdata    = mem[mem_addr];
    assign w1_mem_rdata = {w1_mem_addr, 24'hC0FFEE};

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
        end
        if (cpu_ack) cpu_ack_cnt <= cpu_ack_cnt + 1;
        if (ld_ack)  ld_ack_cnt  <= ld_ack_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic is_ld, input logic we, input logic [7:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output int lat);
        lat = 0;
        rd  = 32'h0;
        if (is_ld) begin
            ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if ((is_ld && ld_ack) || (!is_ld && cpu_ack)) begin
                lat = k;
                rd  = is_ld ? ld_rdata : cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        int          we_base, ack_base, n, cpu_left, ld_left, acks, first;
        logic        order [6];
        logic        exp_order [6];

`ifdef MEM_ARB_RR_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
        mem[8'h10] <= 32'h2010_0005;

        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h0; cpu_wdata = 32'h0;
        ld_req  = 1'b0; ld_we  = 1'b0; ld_addr  = 8'h0; ld_wdata  = 32'h0;
        w1_cpu_req = 1'b0; w1_cpu_we = 1'b0; w1_cpu_addr = 8'h07; w1_cpu_wdata = 32'h0;
        w1_ld_req  = 1'b0; w1_ld_we  = 1'b0; w1_ld_addr  = 8'h0;  w1_ld_wdata  = 32'h0;
        for (int i = 0; i < 6; i++) order[i] = 1'bx;

        // Reset state
        tick(); tick();
        check("rst_state", dbg_state, 2'd0);
        check("rst_cpu_ack", cpu_ack, 1'b0);
        check("rst_ld_ack", ld_ack, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_ld_rdata", ld_rdata, 32'h0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b1;
        tick();

        // CPU read of 0x10, cycle-by-cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        #1;
        check("t1_stall_c0", cpu_stall, 1'b1);
        tick();
        check("t1_stall_c1", cpu_stall, 1'b1);
        check("t1_ack_c1", cpu_ack, 1'b0);
        check("t1_state_c1", dbg_state, 2'd1);
        check("t1_addr_c1", mem_addr, 8'h10);
        tick();
        check("t1_stall_c2", cpu_stall, 1'b1);
        check("t1_we_c2", mem_we, 1'b0);
        tick();
        check("t1_ack_c3", cpu_ack, 1'b1);
        check("t1_rdata_c3", cpu_rdata, 32'h2010_0005);
        check("t1_stall_c3", cpu_stall, 1'b0);
        check("t1_state_c3", dbg_state, 2'd2);
        cpu_req = 1'b0;
        tick();
        check("t1_ack_c4", cpu_ack, 1'b0);
        check("t1_state_c4", dbg_state, 2'd0);
        check("t1_no_write", we_cnt, 0);

        // Loader write 0xDEADBEEF to 0x04, then CPU read back
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h04; ld_wdata = 32'hDEAD_BEEF;
        tick();
        check("t2_we_busy1", mem_we, 1'b0);
        tick();
        check("t2_we_busy2", mem_we, 1'b1);
        check("t2_wdata_busy2", mem_wdata, 32'hDEAD_BEEF);
        check("t2_addr_busy2", mem_addr, 8'h04);
        tick();
        check("t2_ld_ack", ld_ack, 1'b1);
        check("t2_cpu_ack", cpu_ack, 1'b0);
        check("t2_ld_rdata", ld_rdata, 32'hA000_0004);
        check("t2_we_ack", mem_we, 1'b0);
        ld_req = 1'b0;
        tick();
        check("t2_we_count", we_cnt, 1);
        check("t2_mem4", mem[8'h04], 32'hDEAD_BEEF);
        xfer(1'b0, 1'b0, 8'h04, 32'h0, rd, lat);
        check("t2_cpu_rd", rd, 32'hDEAD_BEEF);
        check("t2_cpu_lat", lat, 3);

        // Simultaneous requests, three per side, after a fresh reset
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 8'h11;
        cpu_left = 3; ld_left = 3; n = 0;
        for (int k = 0; k < 100 && n < 6; k++) begin
            tick();
            if (cpu_ack) begin
                order[n] = 1'b0; n++; cpu_left--;
                if (cpu_left == 0) cpu_req = 1'b0;
            end
            if (ld_ack) begin
                order[n] = 1'b1; n++; ld_left--;
                if (ld_left == 0) ld_req = 1'b0;
            end
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        check("t3_grant_count", n, 6);
        for (int i = 0; i < 6; i++) check($sformatf("t3_grant%0d", i), order[i], exp_order[i]);
        tick();

        // CPU write 0x1 to 0x20, req dropped in first BUSY cycle
        we_base = we_cnt; ack_base = cpu_ack_cnt;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 32'h1;
        tick();
        cpu_req = 1'b0;
        tick();
        check("t4_we_busy2", mem_we, 1'b1);
        tick();
        check("t4_ack", cpu_ack, 1'b1);
        tick();
        tick();
        check("t4_idle_after", dbg_state, 2'd0);
        check("t4_ack_after", cpu_ack, 1'b0);
        check("t4_ack_pulses", cpu_ack_cnt - ack_base, 1);
        check("t4_we_pulses", we_cnt - we_base, 1);
        check("t4_mem20", mem[8'h20], 32'h1);

        // Reset during BUSY of a loader write to 0x30
        we_base = we_cnt; ack_base = ld_ack_cnt;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h30; ld_wdata = 32'h5555_AAAA;
        tick();
        check("t5_state_busy", dbg_state, 2'd1);
        rst = 1'b0; ld_req = 1'b0;
        #1;
        check("t5_we_in_rst", mem_we, 1'b0);
        tick();
        check("t5_state_rst", dbg_state, 2'd0);
        check("t5_ld_ack_rst", ld_ack, 1'b0);
        check("t5_addr_rst", mem_addr, 8'h0);
        rst = 1'b1;
        tick(); tick(); tick();
        check("t5_no_ack", ld_ack_cnt - ack_base, 0);
        check("t5_no_write", we_cnt - we_base, 0);
        check("t5_mem30", mem[8'h30], 32'hA000_0030);

        // WAIT_CYCLES=1 instance, CPU request held continuously
        w1_cpu_req = 1'b1;
        acks = 0; first = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (w1_cpu_ack) begin
                acks++;
                if (first == 0) begin
                    first = k;
                    check("t6_first_rdata", w1_cpu_rdata, 32'h07C0_FFEE);
                    check("t6_stall_ack", w1_cpu_stall, 1'b0);
                end
            end
        end
        w1_cpu_req = 1'b0;
        check("t6_first_ack", first, 2);
        check("t6_ack_count", acks, 10);
        tick(); tick();
        check("t6_idle_end", w1_dbg_state, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
